hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined processor. It tracks in-flight register writes across the post-decode stages in a shift-register scoreboard. Each cycle it produces the fetch/decode stall, the decode-to-execute bubble, and registered per-operand forwarding selects for the execute stage. It also counts stall and flush cycles. It replaces the current pipeline's lack of hazard handling and sits beside the Decode stage, between the pipeline registers and the register file.

---
 rtl/hazard_scoreboard.sv | 167 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes after decode and
// produces the fetch/decode stall, the D/E bubble and the execute-stage
// forwarding selects. Also counts stall and flush cycles.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   dec_valid        valid instruction in decode
//   dec_src_used     per-operand "reads a register" flags
//   dec_src_addr     operand addresses, operand i at [i*AW +: AW]
//   dec_wr, dec_wa   decode destination write enable and address
//   dec_is_load      destination is produced by data memory
//   flush            taken branch / PC redirect this cycle
//   stall_fd         hold PC and F/D register (combinational)
//   bubble_e         load a bubble into D/E (combinational)
//   fwd_sel          registered per-operand forwarding select
//   slot_valid       registered scoreboard valid bits
//   stall_cnt        saturating stall-cycle counter
//   flush_cnt        saturating flush counter
module hazard_scoreboard #(
  parameter int AW          = 4,
  parameter int STAGES      = 3,
  parameter int NSRC        = 2,
  parameter int LOAD_LAT    = 2,
  parameter int FWD_EN      = 1,
  parameter int FLUSH_SLOTS = 2,
  parameter int SW          = $clog2(STAGES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  input  logic [NSRC-1:0]      dec_src_used,
  input  logic [NSRC*AW-1:0]   dec_src_addr,
  input  logic                 dec_wr,
  input  logic [AW-1:0]        dec_wa,
  input  logic                 dec_is_load,
  input  logic                 flush,
  output logic                 stall_fd,
  output logic                 bubble_e,
  output logic [NSRC*SW-1:0]   fwd_sel,
  output logic [STAGES-1:0]    slot_valid,
  output logic [15:0]          stall_cnt,
  output logic [15:0]          flush_cnt
);

  // Scoreboard slots: slot 0 = E, slot STAGES-1 = W.
  logic [STAGES-1:0]         v_q, v_d;
  logic [STAGES-1:0]         wr_q, wr_d;
  logic [STAGES-1:0]         ld_q, ld_d;
  logic [STAGES-1:0][AW-1:0] wa_q, wa_d;

  logic [NSRC*SW-1:0] fwd_q, fwd_d;
  logic [15:0]        scnt_q, scnt_d;
  logic [15:0]        fcnt_q, fcnt_d;

  logic [NSRC-1:0]         hit;
  logic [NSRC-1:0][SW-1:0] yk;
  logic [NSRC-1:0]         yld;
  logic [NSRC-1:0]         near;
  logic [NSRC-1:0]         haz;
  logic                    any_haz;
  logic                    issue;

  // Youngest matching slot per operand: scanning oldest to youngest
  // lets the lowest index overwrite any older match.
  always_comb begin
    hit = '0;
    yk  = '0;
    yld = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = STAGES-1; k >= 0; k--) begin
        if (dec_src_used[i] && v_q[k] && wr_q[k] &&
            wa_q[k] == dec_src_addr[i*AW +: AW]) begin
          hit[i] = 1'b1;
          yk[i]  = SW'(k);
          yld[i] = ld_q[k];
        end
      end
    end
  end

  // A match in W is covered by the write-through register file,
  // so only matches in slots 0..STAGES-2 can cause a hazard.
  always_comb begin
    near = '0;
    haz  = '0;
    for (int i = 0; i < NSRC; i++) begin
      near[i] = hit[i] && (int'(yk[i]) <= STAGES-2);
      if (near[i]) begin
        if (FWD_EN != 0) begin
          // Operand is consumed one slot further on (k+1).
          haz[i] = (int'(yk[i]) + 1) <
                   (yld[i] ? LOAD_LAT : 1);
        end else begin
          haz[i] = 1'b1;
        end
      end
    end
  end

  assign any_haz  = |haz;
  assign stall_fd = dec_valid & any_haz & ~flush;
  assign bubble_e = stall_fd | flush;
  assign issue    = dec_valid & ~stall_fd & ~flush;

  always_comb begin
    v_d  = '0;
    wr_d = '0;
    wa_d = '0;
    ld_d = '0;
    v_d[0]  = issue;
    wr_d[0] = dec_wr;
    wa_d[0] = dec_wa;
    ld_d[0] = dec_is_load;
    for (int k = 1; k < STAGES; k++) begin
      v_d[k]  = (flush && k < FLUSH_SLOTS) ? 1'b0 : v_q[k-1];
      wr_d[k] = wr_q[k-1];
      wa_d[k] = wa_q[k-1];
      ld_d[k] = ld_q[k-1];
    end
  end

  always_comb begin
    fwd_d = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (FWD_EN != 0 && issue && near[i]) begin
        fwd_d[i*SW +: SW] = SW'(int'(yk[i]) + 1);
      end
    end
  end

  always_comb begin
    scnt_d = scnt_q;
    fcnt_d = fcnt_q;
    if (stall_fd && scnt_q != 16'hFFFF) begin
      scnt_d = scnt_q + 16'd1;
    end
    if (flush && fcnt_q != 16'hFFFF) begin
      fcnt_d = fcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      wr_q   <= '0;
      ld_q   <= '0;
      wa_q   <= '0;
      fwd_q  <= '0;
      scnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      v_q    <= v_d;
      wr_q   <= wr_d;
      ld_q   <= ld_d;
      wa_q   <= wa_d;
      fwd_q  <= fwd_d;
      scnt_q <= scnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign fwd_sel    = fwd_q;
  assign slot_valid = v_q;
  assign stall_cnt  = scnt_q;
  assign flush_cnt  = fcnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: drives a forwarding-mode and a stall-only
// instance with shared stimulus and checks both against a list model.
module tb_hazard_scoreboard;

  localparam int AW = 4;
  localparam int STAGES = 3;
  localparam int NSRC = 2;
  localparam int LOAD_LAT = 2;
  localparam int FLUSH_SLOTS = 2;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dec_valid = 1'b0;
  logic [NSRC-1:0] dec_src_used = '0;
  logic [NSRC*AW-1:0] dec_src_addr = '0;
  logic dec_wr = 1'b0;
  logic [AW-1:0] dec_wa = '0;
  logic dec_is_load = 1'b0;
  logic flush = 1'b0;

  // index 1 = forwarding instance, index 0 = stall-only instance
  logic [1:0] sfd, be;
  logic [1:0][NSRC*SW-1:0] fs;
  logic [1:0][STAGES-1:0] sv;
  logic [1:0][15:0] sc, fc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .AW(AW), .STAGES(STAGES), .NSRC(NSRC),
    .LOAD_LAT(LOAD_LAT), .FWD_EN(1),
    .FLUSH_SLOTS(FLUSH_SLOTS)
  ) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid),
    .dec_src_used(dec_src_used),
    .dec_src_addr(dec_src_addr),
    .dec_wr(dec_wr), .dec_wa(dec_wa),
    .dec_is_load(dec_is_load), .flush(flush),
    .stall_fd(sfd[1]), .bubble_e(be[1]),
    .fwd_sel(fs[1]), .slot_valid(sv[1]),
    .stall_cnt(sc[1]), .flush_cnt(fc[1])
  );

  hazard_scoreboard #(
    .AW(AW), .STAGES(STAGES), .NSRC(NSRC),
    .LOAD_LAT(LOAD_LAT), .FWD_EN(0),
    .FLUSH_SLOTS(FLUSH_SLOTS)
  ) dut0 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid),
    .dec_src_used(dec_src_used),
    .dec_src_addr(dec_src_addr),
    .dec_wr(dec_wr), .dec_wa(dec_wa),
    .dec_is_load(dec_is_load), .flush(flush),
    .stall_fd(sfd[0]), .bubble_e(be[0]),
    .fwd_sel(fs[0]), .slot_valid(sv[0]),
    .stall_cnt(sc[0]), .flush_cnt(fc[0])
  );

  // Model: list of in-flight instructions with their current stage.
  typedef struct {
    int m;
    int pos;
    bit wr;
    int wa;
    bit ld;
  } rec_t;

  rec_t q[$];
  logic [NSRC*SW-1:0] fexp[2];
  int scm[2];
  int fcm[2];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [STAGES-1:0] mask;
    logic [NSRC*SW-1:0] nf[2];
    bit iss[2];
    bit hz;
    bit stl;
    int best;
    bit bl;
    int addr;
    int rdy;
    rec_t r;
    rec_t nq[$];
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      mask = '0;
      foreach (q[j]) if (q[j].m == m) mask[q[j].pos] = 1'b1;
      check($sformatf("m%0d slot_valid", m), 32'(sv[m]), 32'(mask));
      check($sformatf("m%0d fwd_sel", m), 32'(fs[m]), 32'(fexp[m]));
      check($sformatf("m%0d stall_cnt", m), 32'(sc[m]), scm[m]);
      check($sformatf("m%0d flush_cnt", m), 32'(fc[m]), fcm[m]);
      hz = 1'b0;
      nf[m] = '0;
      for (int i = 0; i < NSRC; i++) begin
        best = -1;
        bl = 1'b0;
        addr = int'(dec_src_addr[i*AW +: AW]);
        if (dec_src_used[i]) begin
          foreach (q[j]) begin
            if (q[j].m == m && q[j].wr && q[j].wa == addr &&
                (best < 0 || q[j].pos < best)) begin
              best = q[j].pos;
              bl = q[j].ld;
            end
          end
        end
        if (best >= 0 && best <= STAGES-2) begin
          if (m == 1) begin
            rdy = bl ? LOAD_LAT : 1;
            if (best + 1 < rdy) hz = 1'b1;
            nf[m][i*SW +: SW] = SW'(best + 1);
          end else begin
            hz = 1'b1;
          end
        end
      end
      stl = dec_valid && hz && !flush;
      iss[m] = dec_valid && !stl && !flush;
      if (!iss[m]) nf[m] = '0;
      check($sformatf("m%0d stall_fd", m), 32'(sfd[m]), 32'(stl));
      check($sformatf("m%0d bubble_e", m), 32'(be[m]),
            32'(stl || flush));
      if (rst) begin
        scm[m] = 0;
        fcm[m] = 0;
        fexp[m] = '0;
      end else begin
        if (stl && scm[m] < 65535) scm[m]++;
        if (flush && fcm[m] < 65535) fcm[m]++;
        fexp[m] = nf[m];
      end
    end
    nq = {};
    if (!rst) begin
      foreach (q[j]) begin
        r = q[j];
        r.pos++;
        if (r.pos >= STAGES) continue;
        if (flush && r.pos < FLUSH_SLOTS) continue;
        nq.push_back(r);
      end
      for (int m = 0; m < 2; m++) begin
        if (iss[m]) begin
          r.m = m;
          r.pos = 0;
          r.wr = dec_wr;
          r.wa = int'(dec_wa);
          r.ld = dec_is_load;
          nq.push_back(r);
        end
      end
    end
    q = nq;
    @(posedge clk);
    #1;
  endtask

  task automatic set_i(input bit v, input bit [1:0] used,
                       input int a0, input int a1,
                       input bit wr, input int wa,
                       input bit ld, input bit fl);
    dec_valid = v;
    dec_src_used = used;
    dec_src_addr = {AW'(a1), AW'(a0)};
    dec_wr = wr;
    dec_wa = AW'(wa);
    dec_is_load = ld;
    flush = fl;
  endtask

  task automatic do_rst();
    set_i(0, 2'b00, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      fexp[m] = '0;
      scm[m] = 0;
      fcm[m] = 0;
    end
    // reset and idle hold
    rst = 1'b1;
    set_i(0, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) cyc();
    check("rst slot_valid", 32'(sv[1]), 32'h0);
    check("rst counters", 32'({sc[1], fc[1]}), 32'h0);

    // ALU producer then dependent read: forward from slot 0
    do_rst();
    set_i(1, 2'b00, 0, 0, 1, 3, 0, 0);
    cyc();
    set_i(1, 2'b01, 3, 0, 0, 0, 0, 0);
    cyc();
    check("alu fwd op0", 32'(fs[1][1:0]), 32'd1);
    check("alu slot_valid", 32'(sv[1]), 32'b011);

    // load-use: one stall then forward from W
    do_rst();
    set_i(1, 2'b00, 0, 0, 1, 5, 1, 0);
    cyc();
    set_i(1, 2'b10, 0, 5, 0, 0, 0, 0);
    cyc();
    cyc();
    check("ld stall_cnt", 32'(sc[1]), 32'd1);
    check("ld fwd op1", 32'(fs[1][3:2]), 32'd2);

    // two writers to r7: youngest wins
    do_rst();
    set_i(1, 2'b00, 0, 0, 1, 7, 0, 0);
    cyc();
    cyc();
    set_i(1, 2'b01, 7, 0, 0, 0, 0, 0);
    cyc();
    check("youngest fwd", 32'(fs[1][1:0]), 32'd1);

    // stall-only instance: two stalls then select 0
    do_rst();
    set_i(1, 2'b00, 0, 0, 1, 2, 0, 0);
    cyc();
    set_i(1, 2'b01, 2, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    cyc();
    check("nofwd stall_cnt", 32'(sc[0]), 32'd2);
    check("nofwd fwd_sel", 32'(fs[0]), 32'd0);

    // flush with all slots valid
    do_rst();
    for (int n = 1; n <= 3; n++) begin
      set_i(1, 2'b00, 0, 0, 1, n, 0, 0);
      cyc();
    end
    check("pre-flush valid", 32'(sv[1]), 32'b111);
    set_i(1, 2'b01, 1, 0, 0, 0, 0, 1);
    cyc();
    check("flush valid", 32'(sv[1]), 32'b100);
    check("flush_cnt", 32'(fc[1]), 32'd1);
    check("flush no stall", 32'(sc[1]), 32'd0);

    // random traffic on a small register range to force hazards
    for (int n = 0; n < 3000; n++) begin
      set_i($urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1) != 0,
            $urandom_range(0, 3),
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      cyc();
    end
    rst = 1'b0;
    set_i(0, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
